alu_seq_core: RTL and testbench

- Device-side responder for the testbench ALU interface.
- Accepts operands a, b and opcode s from the driver side; produces a 2*WIDTH-bit result "out" for the monitor side.
- Single-cycle ops complete with latency 1.
- MUL/DIV run on an iterative shift unit (latency WIDTH); input is stalled meanwhile.
- Sits directly under the top-level DUT wrapper bound to the interface.

---
 rtl/alu_pkg.sv | 40 ++++
 rtl/alu_muldiv_iter.sv | 87 ++++++++
 rtl/alu_seq_core.sv | 141 ++++++++++++++
 tb/tb_alu_seq_core.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU core: opcodes, FSM states, flag bit positions.
// Flag indices apply when the core is built with ALU_FLAGS_EN.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_MUL = 4'd2,
    OP_DIV = 4'd3,
    OP_AND = 4'd4,
    OP_OR  = 4'd5,
    OP_XOR = 4'd6,
    OP_NOT = 4'd7,
    OP_SHL = 4'd8,
    OP_SHR = 4'd9,
    OP_ROL = 4'd10,
    OP_ROR = 4'd11,
    OP_INC = 4'd12,
    OP_DEC = 4'd13,
    OP_CMP = 4'd14,
    OP_CAT = 4'd15
  } alu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } alu_state_e;

  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_NEG   = 2;
  localparam int FLAG_OVF   = 3;
  localparam int FLAG_DIVZ  = 4;
  localparam int NUM_FLAGS  = 5;

  function automatic logic is_multicycle(input alu_op_e op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unit: shift-add multiplier or restoring divider, one bit per clock.
// done pulses on the final iteration; result is that iteration's outcome.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  alu_op_e              op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result
);

  localparam int CW = $clog2(WIDTH);

  logic               busy;
  logic [CW-1:0]      cnt;
  logic               is_div;
  // MUL: acc = partial product, opnd = shifted multiplicand, shreg = multiplier.
  // DIV: acc[WIDTH-1:0] = remainder, opnd = divisor, shreg = dividend -> quotient.
  logic [2*WIDTH-1:0] acc, opnd;
  logic [WIDTH-1:0]   shreg;

  logic [2*WIDTH-1:0] acc_nxt, opnd_nxt;
  logic [WIDTH-1:0]   shreg_nxt;
  logic [WIDTH:0]     shifted, trial;

  // NOTE: every variable gets a default at the top so no path leaves one unassigned (no latches).
  always_comb begin
    shifted   = {acc[WIDTH-1:0], shreg[WIDTH-1]};
    trial     = shifted - {1'b0, opnd[WIDTH-1:0]};
    acc_nxt   = acc;
    opnd_nxt  = opnd;
    shreg_nxt = shreg;
    if (is_div) begin
      // Remainder stays below the divisor, so a non-negative trial always fits WIDTH bits.
      if (!trial[WIDTH]) begin
        acc_nxt   = {{WIDTH{1'b0}}, trial[WIDTH-1:0]};
        shreg_nxt = {shreg[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt   = {{WIDTH{1'b0}}, shifted[WIDTH-1:0]};
        shreg_nxt = {shreg[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_nxt   = acc + (shreg[0] ? opnd : '0);
      opnd_nxt  = opnd << 1;
      shreg_nxt = shreg >> 1;
    end
  end

  assign done   = busy && (cnt == CW'(WIDTH - 1));
  assign result = is_div ? {acc_nxt[WIDTH-1:0], shreg_nxt} : acc_nxt;

  // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      cnt    <= '0;
      is_div <= 1'b0;
      acc    <= '0;
      opnd   <= '0;
      shreg  <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= '0;
      is_div <= (op == OP_DIV);
      acc    <= '0;
      opnd   <= (op == OP_DIV) ? {{WIDTH{1'b0}}, b} : {{WIDTH{1'b0}}, a};
      shreg  <= (op == OP_DIV) ? a : b;
    end else if (busy) begin
      acc   <= acc_nxt;
      opnd  <= opnd_nxt;
      shreg <= shreg_nxt;
      if (done) begin
        busy <= 1'b0;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_seq_core.sv
// Sequential ALU core: single-cycle ops answer next cycle, MUL/DIV stall input for WIDTH cycles.
// Define ALU_FLAGS_EN to add the registered flags[4:0] = {divz, ovf, neg, carry, zero} output.
module alu_seq_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [3:0]           s,
  output logic [2*WIDTH-1:0]   out,
  output logic                 out_valid
`ifdef ALU_FLAGS_EN
  ,
  output logic [NUM_FLAGS-1:0] flags
`endif
);

  localparam int SW = $clog2(WIDTH);

  alu_state_e         state, state_nxt;
  alu_op_e            op;
  logic               accept, md_start, md_done, load;
  logic [2*WIDTH-1:0] md_result, sc_result, load_val;
  logic [2*WIDTH-1:0] ax, bx;
  logic [WIDTH-1:0]   rol_w, ror_w;
  logic [SW-1:0]      sh;

  assign op       = alu_op_e'(s);
  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;
  assign md_start = accept && is_multicycle(op);

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (md_start),
    .op     (op),
    .a      (a),
    .b      (b),
    .done   (md_done),
    .result (md_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (md_start) state_nxt = BUSY;
      BUSY:    if (md_done)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ax        = {{WIDTH{1'b0}}, a};
    bx        = {{WIDTH{1'b0}}, b};
    sh        = b[SW-1:0];
    rol_w     = WIDTH'(({a, a} << sh) >> WIDTH);
    ror_w     = WIDTH'({a, a} >> sh);
    sc_result = '0;
    case (op)
      OP_ADD:  sc_result = ax + bx;
      OP_SUB:  sc_result = ax - bx;
      OP_AND:  sc_result = ax & bx;
      OP_OR:   sc_result = ax | bx;
      OP_XOR:  sc_result = ax ^ bx;
      OP_NOT:  sc_result = {{WIDTH{1'b0}}, ~a};
      OP_SHL:  sc_result = ax << sh;
      OP_SHR:  sc_result = ax >> sh;
      OP_ROL:  sc_result = {{WIDTH{1'b0}}, rol_w};
      OP_ROR:  sc_result = {{WIDTH{1'b0}}, ror_w};
      OP_INC:  sc_result = ax + 1'b1;
      OP_DEC:  sc_result = ax - 1'b1;
      OP_CMP:  sc_result = {{(2*WIDTH-3){1'b0}}, (a < b), (a > b), (a == b)};
      OP_CAT:  sc_result = {a, b};
      default: sc_result = '0;
    endcase
  end

  // md_done only occurs in BUSY and accept only in IDLE, so the two loads never collide.
  assign load     = md_done || (accept && !is_multicycle(op));
  assign load_val = md_done ? md_result : sc_result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= load;
      if (load) out <= load_val;
    end
  end

`ifdef ALU_FLAGS_EN
  logic                 div_zero;
  logic [NUM_FLAGS-1:0] flags_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        div_zero <= 1'b0;
    else if (md_start) div_zero <= (op == OP_DIV) && (b == '0);
  end

  always_comb begin
    flags_nxt            = '0;
    flags_nxt[FLAG_ZERO] = (load_val == '0);
    flags_nxt[FLAG_NEG]  = load_val[2*WIDTH-1];
    if (md_done) begin
      flags_nxt[FLAG_DIVZ] = div_zero;
    end else begin
      case (op)
        OP_ADD: begin
          flags_nxt[FLAG_CARRY] = load_val[WIDTH];
          flags_nxt[FLAG_OVF]   = (a[WIDTH-1] == b[WIDTH-1]) && (load_val[WIDTH-1] != a[WIDTH-1]);
        end
        OP_SUB: begin
          flags_nxt[FLAG_CARRY] = (a < b);
          flags_nxt[FLAG_OVF]   = (a[WIDTH-1] != b[WIDTH-1]) && (load_val[WIDTH-1] != a[WIDTH-1]);
        end
        OP_INC:  flags_nxt[FLAG_CARRY] = load_val[WIDTH];
        OP_DEC:  flags_nxt[FLAG_CARRY] = (a == '0);
        default: flags_nxt[FLAG_CARRY] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    flags <= '0;
    else if (load) flags <= flags_nxt;
  end
`endif

endmodule

// File: tb/tb_alu_seq_core.sv
// Self-checking bench for alu_seq_core: directed vectors plus randomized traffic against an
// arithmetic reference model. Build with ALU_FLAGS_EN to also check the flags output.
module tb_alu_seq_core;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [3:0]  s;
  logic [15:0] out;
  logic        out_valid;
`ifdef ALU_FLAGS_EN
  logic [4:0]  flags;
`endif

  int asserts = 0;
  int fails   = 0;

  alu_seq_core #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .s         (s),
    .out       (out),
    .out_valid (out_valid)
`ifdef ALU_FLAGS_EN
    ,
    .flags     (flags)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Result as plain integer arithmetic on the zero-extended operands, wrapped to 16 bits.
  function automatic logic [15:0] model(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y);
    int ix = x;
    int iy = y;
    int sh = y % 8;
    int r;
    case (op)
      4'd0:  r = ix + iy;
      4'd1:  r = ix - iy;
      4'd2:  r = ix * iy;
      4'd3:  r = (iy == 0) ? (ix * 256 + 255) : ((ix % iy) * 256 + ix / iy);
      4'd4:  r = ix & iy;
      4'd5:  r = ix | iy;
      4'd6:  r = ix ^ iy;
      4'd7:  r = 255 - ix;
      4'd8:  r = ix << sh;
      4'd9:  r = ix >> sh;
      4'd10: r = ((ix << sh) | (ix >> (8 - sh))) & 255;
      4'd11: r = ((ix >> sh) | (ix << (8 - sh))) & 255;
      4'd12: r = ix + 1;
      4'd13: r = ix - 1;
      4'd14: r = (ix == iy) ? 1 : ((ix > iy) ? 2 : 4);
      default: r = ix * 256 + iy;
    endcase
    return r[15:0];
  endfunction

`ifdef ALU_FLAGS_EN
  // {divz, ovf, neg, carry, zero}
  function automatic logic [4:0] flag_model(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y);
    logic [15:0] r;
    int sx, sy, sr;
    logic divz, ovf, carry;
    r     = model(op, x, y);
    sx    = (x >= 128) ? int'(x) - 256 : int'(x);
    sy    = (y >= 128) ? int'(y) - 256 : int'(y);
    divz  = 1'b0;
    ovf   = 1'b0;
    carry = 1'b0;
    case (op)
      4'd0: begin
        carry = (int'(x) + int'(y)) > 255;
        sr    = sx + sy;
        ovf   = (sr > 127) || (sr < -128);
      end
      4'd1: begin
        carry = x < y;
        sr    = sx - sy;
        ovf   = (sr > 127) || (sr < -128);
      end
      4'd3:  divz  = (y == 0);
      4'd12: carry = (x == 8'hFF);
      4'd13: carry = (x == 0);
      default: ;
    endcase
    return {divz, ovf, r[15], carry, (r == 16'h0)};
  endfunction
`endif

  // One transaction with idle gaps around it: checks latency, stall, result and pulse width.
  task automatic transact(input string name, input logic [3:0] op, input logic [7:0] ta,
                          input logic [7:0] tb, input logic [15:0] exp, input bit noise);
    int lat;
    int exp_lat;
    exp_lat = (op == 4'd2 || op == 4'd3) ? 8 : 0;
    @(negedge clk);
    asserts++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s ready_before: in_ready=%b expected 1", name, in_ready);
    end
    a = ta; b = tb; s = op; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      asserts++;
      if (in_ready !== 1'b0) begin
        fails++;
        $display("FAIL %s stall: in_ready=%b expected 0 at cycle %0d", name, in_ready, lat);
      end
      if (noise && lat < exp_lat - 1) begin
        in_valid = 1'b1; s = 4'd0; a = 8'($urandom); b = 8'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    asserts++;
    if (lat !== exp_lat) begin
      fails++;
      $display("FAIL %s latency: got %0d cycles expected %0d", name, lat, exp_lat);
    end
    asserts++;
    if (out !== exp) begin
      fails++;
      $display("FAIL %s out: got %h expected %h", name, out, exp);
    end
    asserts++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s ready_at_result: in_ready=%b expected 1", name, in_ready);
    end
`ifdef ALU_FLAGS_EN
    asserts++;
    if (flags !== flag_model(op, ta, tb)) begin
      fails++;
      $display("FAIL %s flags: got %b expected %b", name, flags, flag_model(op, ta, tb));
    end
`endif
    @(posedge clk); #1;
    asserts++;
    if (out_valid !== 1'b0 || out !== exp) begin
      fails++;
      $display("FAIL %s hold: out_valid=%b out=%h expected 0 and %h", name, out_valid, out, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; s = '0;
    #1;
    asserts++;
    if (out !== 16'h0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset: out=%h out_valid=%b in_ready=%b expected 0000 0 1", out, out_valid, in_ready);
    end
`ifdef ALU_FLAGS_EN
    asserts++;
    if (flags !== 5'b0) begin
      fails++;
      $display("FAIL reset_flags: got %b expected 00000", flags);
    end
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    transact("add_carry", 4'd0,  8'hFF, 8'h01, 16'h0100, 1'b0);
    transact("mul_max",   4'd2,  8'hFF, 8'hFF, 16'hFE01, 1'b1);
    transact("div_200_7", 4'd3,  8'd200, 8'd7, 16'h041C, 1'b0);
    transact("div_zero",  4'd3,  8'h2A, 8'h00, 16'h2AFF, 1'b1);
    transact("rol",       4'd10, 8'h81, 8'h01, 16'h0003, 1'b0);
    transact("cmp_lt",    4'd14, 8'd5,  8'd9,  16'h0004, 1'b0);
    transact("cat",       4'd15, 8'hAB, 8'hCD, 16'hABCD, 1'b0);
    transact("dec_zero",  4'd13, 8'h00, 8'h55, 16'hFFFF, 1'b0);
    transact("not",       4'd7,  8'h0F, 8'h00, 16'h00F0, 1'b0);
  endtask

  // Accepts on consecutive edges; each result must appear the cycle after its accept.
  task automatic test_back_to_back();
    logic [3:0]  ops[$];
    logic [7:0]  as[$];
    logic [7:0]  bs[$];
    logic [15:0] exp;
    ops = '{4'd1, 4'd6};
    as  = '{8'd3, 8'hF0};
    bs  = '{8'd5, 8'h3C};
    for (int i = 0; i < 24; i++) begin
      logic [3:0] op;
      do op = 4'($urandom_range(0, 15)); while (op == 4'd2 || op == 4'd3);
      ops.push_back(op);
      as.push_back(8'($urandom));
      bs.push_back(8'($urandom));
    end
    @(negedge clk);
    a = as[0]; b = bs[0]; s = ops[0]; in_valid = 1'b1;
    for (int k = 0; k < ops.size(); k++) begin
      @(posedge clk); #1;
      exp = model(ops[k], as[k], bs[k]);
      asserts++;
      if (out_valid !== 1'b1 || out !== exp || in_ready !== 1'b1) begin
        fails++;
        $display("FAIL b2b[%0d] op=%0d: out=%h out_valid=%b in_ready=%b expected %h 1 1",
                 k, ops[k], out, out_valid, in_ready, exp);
      end
      @(negedge clk);
      if (k + 1 < ops.size()) begin
        a = as[k+1]; b = bs[k+1]; s = ops[k+1];
      end else begin
        in_valid = 1'b0;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 120; i++) begin
      logic [3:0] op;
      logic [7:0] ra, rb;
      op = 4'($urandom_range(0, 15));
      ra = 8'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      transact("random", op, ra, rb, model(op, ra, rb), 1'($urandom));
    end
  endtask

  task automatic test_reset_mid_busy();
    transact("add_pre", 4'd0, 8'h40, 8'h41, 16'h0081, 1'b0);
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; s = 4'd2; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    asserts++;
    if (out !== 16'h0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_busy: out=%h out_valid=%b in_ready=%b expected 0000 0 1", out, out_valid, in_ready);
    end
    repeat (6) begin
      @(posedge clk); #1;
      asserts++;
      if (out_valid !== 1'b0) begin
        fails++;
        $display("FAIL reset_busy_pulse: out_valid=%b expected 0", out_valid);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    transact("add_after_reset", 4'd0, 8'd1, 8'd1, 16'h0002, 1'b0);
    repeat (6) begin
      @(posedge clk); #1;
      asserts++;
      if (out_valid !== 1'b0 || out !== 16'h0002) begin
        fails++;
        $display("FAIL reset_no_stale: out_valid=%b out=%h expected 0 0002", out_valid, out);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_mid_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
